// File: rtl/secded_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : secded_pkg
// Brief  : Shared types and constants for the SECDED error injector.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package secded_pkg;

   localparam int          CW_W      = 72;
   // Taps of x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   typedef enum logic [2:0] {
      MODE_OFF  = 3'd0,
      MODE_FIX1 = 3'd1,
      MODE_FIX2 = 3'd2,
      MODE_RND1 = 3'd3,
      MODE_RND2 = 3'd4
   } inj_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_CONT  = 2'd2
   } inj_state_t;

   function automatic logic [6:0] fold72(input logic [6:0] v);
      return (v >= 7'd72) ? (v - 7'd72) : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/secded_error_injector_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : secded_error_injector_if
// Brief  : Codeword stream and injection-control bundle for the injector.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface secded_error_injector_if #(
   parameter int CNT_W = 16
);
   import secded_pkg::*;

   logic             valid_in;
   logic [CW_W-1:0]  data_in;
   logic [2:0]       inj_mode;
   logic [6:0]       inj_pos0;
   logic [6:0]       inj_pos1;
   logic             inj_arm;
   logic             inj_cont;
   logic             clr_count;
   logic             valid_out;
   logic [CW_W-1:0]  data_out;
   logic [1:0]       inj_flag;
   logic [CNT_W-1:0] inj_count;

   modport master (
      output valid_in, data_in, inj_mode, inj_pos0, inj_pos1,
             inj_arm, inj_cont, clr_count,
      input  valid_out, data_out, inj_flag, inj_count
   );

   modport slave (
      input  valid_in, data_in, inj_mode, inj_pos0, inj_pos1,
             inj_arm, inj_cont, clr_count,
      output valid_out, data_out, inj_flag, inj_count
   );

endinterface
`default_nettype wire

// File: rtl/secded_lfsr16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : secded_lfsr16
// Brief  : 16-bit Fibonacci LFSR that steps once per advance pulse.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module secded_lfsr16
   import secded_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance,
   output logic [15:0] state
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   always_comb begin
      state_d = state_q;
      if (advance) begin
         state_d = {^(state_q & LFSR_TAPS), state_q[15:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/secded_error_injector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : secded_error_injector
// Brief  : Flips 0-2 bits of a 72-bit SECDED codeword on demand, 1-cycle latency.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module secded_error_injector
   import secded_pkg::*;
#(
   parameter int          DATA_W    = 72,
   parameter int          CNT_W     = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   secded_error_injector_if.slave  bus
);

   localparam logic [CW_W-1:0] c_one = {{(CW_W-1){1'b0}}, 1'b1};

   generate
      if (DATA_W != CW_W) begin : g_bad_width
         $error("secded_error_injector supports only DATA_W = 72");
      end
      if (LFSR_SEED == 16'h0000) begin : g_bad_seed
         $error("secded_error_injector: LFSR_SEED must be non-zero");
      end
   endgenerate

   inj_state_t       state_q, state_d;
   logic [CW_W-1:0]  data_q;
   logic             valid_q;
   logic [1:0]       flag_q;
   logic [CNT_W-1:0] count_q, count_d;

   logic [15:0]      w_lfsr;
   inj_mode_t        w_mode;
   logic [6:0]       w_rnd_p0, w_rnd_p1;
   logic [CW_W-1:0]  w_mask;
   logic [1:0]       w_flag;
   logic             w_inject;
   logic             w_unused_lfsr;

   secded_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (bus.valid_in),
      .state   (w_lfsr)
   );

   assign w_unused_lfsr = ^{w_lfsr[15], w_lfsr[7]};

   always_comb begin
      state_d = state_q;
      if (bus.inj_cont) begin
         state_d = ST_CONT;
      end else begin
         case (state_q)
            ST_IDLE:  if (bus.inj_arm)  state_d = ST_ARMED;
            ST_ARMED: if (bus.valid_in) state_d = ST_IDLE;
            ST_CONT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Shifting by a position >= 72 naturally yields an empty mask.
   always_comb begin
      w_mode   = (bus.inj_mode > 3'd4) ? MODE_OFF : inj_mode_t'(bus.inj_mode);
      w_rnd_p0 = fold72(w_lfsr[6:0]);
      w_rnd_p1 = fold72(w_lfsr[14:8]);
      if (w_rnd_p1 == w_rnd_p0) begin
         w_rnd_p1 = (w_rnd_p0 == 7'd71) ? 7'd0 : (w_rnd_p0 + 7'd1);
      end
      w_inject = bus.valid_in && ((state_q == ST_ARMED) || (state_q == ST_CONT));
      w_mask   = '0;
      if (w_inject) begin
         case (w_mode)
            MODE_FIX1: w_mask = c_one << bus.inj_pos0;
            MODE_FIX2: w_mask = (c_one << bus.inj_pos0) | (c_one << bus.inj_pos1);
            MODE_RND1: w_mask = c_one << w_rnd_p0;
            MODE_RND2: w_mask = (c_one << w_rnd_p0) | (c_one << w_rnd_p1);
            default:   w_mask = '0;
         endcase
      end
      w_flag = 2'($countones(w_mask));
   end

   always_comb begin
      count_d = count_q;
      if (bus.clr_count) begin
         count_d = '0;
      end else if (bus.valid_in && (w_flag != 2'd0) && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         flag_q  <= 2'd0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= bus.valid_in;
         count_q <= count_d;
         if (bus.valid_in) begin
            data_q <= bus.data_in ^ w_mask;
            flag_q <= w_flag;
         end
      end
   end

   assign bus.valid_out = valid_q;
   assign bus.data_out  = data_q;
   assign bus.inj_flag  = flag_q;
   assign bus.inj_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_secded_error_injector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_secded_error_injector
// Brief  : Self-checking bench with a behavioural injector and SECDED model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_secded_error_injector;
   import secded_pkg::*;

   localparam int          c_cnt_w = 16;
   localparam logic [15:0] c_seed  = 16'hACE1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;

   logic [15:0] m_lfsr;
   int unsigned m_count;

   secded_error_injector_if #(.CNT_W(c_cnt_w)) bus ();

   secded_error_injector #(
      .DATA_W    (72),
      .CNT_W     (c_cnt_w),
      .LFSR_SEED (c_seed)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference LFSR: bit = s ^ s>>2 ^ s>>3 ^ s>>5, shifted in at the top.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      int unsigned v, b;
      v = s;
      b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
      return 16'((v >> 1) | (b << 15));
   endfunction

   function automatic logic [71:0] model_mask(input int mode, input int p0, input int p1,
                                              input logic [15:0] s);
      logic [71:0] m;
      int r0, r1;
      m  = '0;
      r0 = int'(s) % 128;
      if (r0 >= 72) r0 -= 72;
      r1 = (int'(s) / 256) % 128;
      if (r1 >= 72) r1 -= 72;
      if (r1 == r0) r1 = (r0 + 1) % 72;
      case (mode)
         1: if (p0 < 72) m[p0] = 1'b1;
         2: begin
            if (p0 < 72) m[p0] = 1'b1;
            if (p1 < 72) m[p1] = 1'b1;
         end
         3: m[r0] = 1'b1;
         4: begin
            m[r0] = 1'b1;
            m[r1] = 1'b1;
         end
         default: m = '0;
      endcase
      return m;
   endfunction

   // Extended Hamming(72,64): parity at powers of two, overall parity at bit 0.
   function automatic logic [71:0] ecc_encode(input logic [63:0] data);
      logic [71:0] cw;
      logic        p;
      int          k;
      cw = '0;
      k  = 0;
      for (int i = 1; i < 72; i++) begin
         if ((i & (i - 1)) != 0) begin
            cw[i] = data[k];
            k++;
         end
      end
      for (int b = 0; b < 7; b++) begin
         p = 1'b0;
         for (int i = 1; i < 72; i++) if (((i >> b) & 1) == 1) p ^= cw[i];
         cw[1 << b] = p;
      end
      cw[0] = ^cw[71:1];
      return cw;
   endfunction

   function automatic logic [1:0] ecc_decode(input logic [71:0] cw);
      int   syn;
      logic par;
      syn = 0;
      for (int i = 1; i < 72; i++) if (cw[i]) syn ^= i;
      par = ^cw;
      return {(!par && syn != 0), par};
   endfunction

   function automatic logic [71:0] rand72();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[71:0];
   endfunction

   task automatic clear_inputs();
      bus.valid_in  = 1'b0;
      bus.data_in   = '0;
      bus.inj_mode  = 3'd0;
      bus.inj_pos0  = 7'd0;
      bus.inj_pos1  = 7'd0;
      bus.inj_arm   = 1'b0;
      bus.inj_cont  = 1'b0;
      bus.clr_count = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      rst_n   = 1'b1;
      m_lfsr  = c_seed;
      m_count = 0;
   endtask

   task automatic send(input logic [71:0] d);
      bus.valid_in = 1'b1;
      bus.data_in  = d;
      step();
      bus.valid_in = 1'b0;
      m_lfsr = lfsr_step(m_lfsr);
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      #1;
      compared += 4;
      if (bus.data_out !== 72'h0) begin
         mismatched++; $display("FAIL reset_data: got %h expected 0", bus.data_out);
      end
      if (bus.valid_out !== 1'b0) begin
         mismatched++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out);
      end
      if (bus.inj_flag !== 2'd0) begin
         mismatched++; $display("FAIL reset_flag: got %0d expected 0", bus.inj_flag);
      end
      if (bus.inj_count !== 16'd0) begin
         mismatched++; $display("FAIL reset_count: got %0d expected 0", bus.inj_count);
      end
      do_reset();
   endtask

   task automatic test_mode0_cont();
      logic [71:0] d;
      do_reset();
      d = 72'h00_DEADBEEF_CAFECAFE;
      bus.inj_cont = 1'b1;
      bus.inj_mode = 3'd0;
      step();
      send(d);
      compared += 4;
      if (bus.valid_out !== 1'b1) begin
         mismatched++; $display("FAIL m0_valid: got %b expected 1", bus.valid_out);
      end
      if (bus.data_out !== d) begin
         mismatched++; $display("FAIL m0_data: got %h expected %h", bus.data_out, d);
      end
      if (bus.inj_flag !== 2'd0) begin
         mismatched++; $display("FAIL m0_flag: got %0d expected 0", bus.inj_flag);
      end
      if (bus.inj_count !== 16'd0) begin
         mismatched++; $display("FAIL m0_count: got %0d expected 0", bus.inj_count);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_fixed_single_arm();
      do_reset();
      bus.inj_mode = 3'd1;
      bus.inj_pos0 = 7'd5;
      bus.inj_arm  = 1'b1;
      step();
      bus.inj_arm = 1'b0;
      send(72'h0);
      compared += 2;
      if (bus.data_out !== 72'h20) begin
         mismatched++; $display("FAIL arm_data1: got %h expected 20", bus.data_out);
      end
      if (bus.inj_flag !== 2'd1) begin
         mismatched++; $display("FAIL arm_flag1: got %0d expected 1", bus.inj_flag);
      end
      send(72'h0);
      compared += 3;
      if (bus.data_out !== 72'h0) begin
         mismatched++; $display("FAIL arm_data2: got %h expected 0", bus.data_out);
      end
      if (bus.inj_flag !== 2'd0) begin
         mismatched++; $display("FAIL arm_flag2: got %0d expected 0", bus.inj_flag);
      end
      if (bus.inj_count !== 16'd1) begin
         mismatched++; $display("FAIL arm_count: got %0d expected 1", bus.inj_count);
      end
      clear_inputs();
   endtask

   task automatic test_fixed_double_cont();
      do_reset();
      bus.inj_cont = 1'b1;
      bus.inj_mode = 3'd2;
      bus.inj_pos0 = 7'd0;
      bus.inj_pos1 = 7'd71;
      step();
      for (int i = 0; i < 3; i++) begin
         send(72'h0);
         compared += 2;
         if (bus.data_out !== 72'h80_00000000_00000001) begin
            mismatched++; $display("FAIL dbl_data[%0d]: got %h expected 800000000000000001", i, bus.data_out);
         end
         if (bus.inj_flag !== 2'd2) begin
            mismatched++; $display("FAIL dbl_flag[%0d]: got %0d expected 2", i, bus.inj_flag);
         end
      end
      compared++;
      if (bus.inj_count !== 16'd3) begin
         mismatched++; $display("FAIL dbl_count: got %0d expected 3", bus.inj_count);
      end
      bus.clr_count = 1'b1;
      send(72'h0);
      bus.clr_count = 1'b0;
      compared += 2;
      if (bus.inj_count !== 16'd0) begin
         mismatched++; $display("FAIL clr_count: got %0d expected 0", bus.inj_count);
      end
      if (bus.inj_flag !== 2'd2) begin
         mismatched++; $display("FAIL clr_flag: got %0d expected 2", bus.inj_flag);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_boundaries();
      logic [71:0] d, e;
      do_reset();
      bus.inj_cont = 1'b1;
      bus.inj_mode = 3'd2;
      bus.inj_pos0 = 7'd10;
      bus.inj_pos1 = 7'd10;
      step();
      d = rand72();
      e = d;
      e[10] = ~e[10];
      send(d);
      compared += 2;
      if (bus.data_out !== e) begin
         mismatched++; $display("FAIL same_pos_data: got %h expected %h", bus.data_out, e);
      end
      if (bus.inj_flag !== 2'd1) begin
         mismatched++; $display("FAIL same_pos_flag: got %0d expected 1", bus.inj_flag);
      end
      step();
      compared += 3;
      if (bus.valid_out !== 1'b0) begin
         mismatched++; $display("FAIL hold_valid: got %b expected 0", bus.valid_out);
      end
      if (bus.data_out !== e) begin
         mismatched++; $display("FAIL hold_data: got %h expected %h", bus.data_out, e);
      end
      if (bus.inj_flag !== 2'd1) begin
         mismatched++; $display("FAIL hold_flag: got %0d expected 1", bus.inj_flag);
      end
      bus.inj_mode = 3'd1;
      bus.inj_pos0 = 7'd100;
      d = rand72();
      send(d);
      compared += 2;
      if (bus.data_out !== d) begin
         mismatched++; $display("FAIL oob_data: got %h expected %h", bus.data_out, d);
      end
      if (bus.inj_flag !== 2'd0) begin
         mismatched++; $display("FAIL oob_flag: got %0d expected 0", bus.inj_flag);
      end
      bus.inj_mode = 3'd7;
      bus.inj_pos0 = 7'd3;
      d = rand72();
      send(d);
      compared += 2;
      if (bus.data_out !== d) begin
         mismatched++; $display("FAIL mode7_data: got %h expected %h", bus.data_out, d);
      end
      if (bus.inj_flag !== 2'd0) begin
         mismatched++; $display("FAIL mode7_flag: got %0d expected 0", bus.inj_flag);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_random_double();
      logic [71:0] d, e;
      do_reset();
      bus.inj_cont = 1'b1;
      bus.inj_mode = 3'd4;
      step();
      for (int i = 0; i < 1000; i++) begin
         d = rand72();
         e = d ^ model_mask(4, 0, 0, m_lfsr);
         send(d);
         compared += 2;
         if (bus.data_out !== e) begin
            mismatched++; $display("FAIL rnd2_data[%0d]: got %h expected %h", i, bus.data_out, e);
         end
         if (bus.inj_flag !== 2'd2) begin
            mismatched++; $display("FAIL rnd2_flag[%0d]: got %0d expected 2", i, bus.inj_flag);
         end
      end
      compared++;
      if (bus.inj_count !== 16'd1000) begin
         mismatched++; $display("FAIL rnd2_count: got %0d expected 1000", bus.inj_count);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_random_mixed();
      logic [71:0] d, mask, exp_data;
      int          exp_flag, mode, p0, p1;
      logic        v, arm, armed, armed_next, exp_valid;
      do_reset();
      armed    = 1'b0;
      exp_data = '0;
      exp_flag = 0;
      for (int i = 0; i < 300; i++) begin
         v    = ($urandom_range(0, 9) < 7);
         arm  = ($urandom_range(0, 3) == 0);
         mode = int'($urandom_range(0, 7));
         p0   = int'($urandom_range(0, 127));
         p1   = int'($urandom_range(0, 127));
         d    = rand72();
         bus.valid_in = v;
         bus.data_in  = d;
         bus.inj_arm  = arm;
         bus.inj_mode = 3'(mode);
         bus.inj_pos0 = 7'(p0);
         bus.inj_pos1 = 7'(p1);
         exp_valid = v;
         if (v) begin
            mask     = armed ? model_mask(mode, p0, p1, m_lfsr) : '0;
            exp_data = d ^ mask;
            exp_flag = $countones(mask);
            if (exp_flag != 0 && m_count != 65535) m_count++;
            m_lfsr = lfsr_step(m_lfsr);
         end
         armed_next = v ? 1'b0 : armed;
         if (!armed && arm) armed_next = 1'b1;
         armed = armed_next;
         step();
         compared += 4;
         if (bus.valid_out !== exp_valid) begin
            mismatched++; $display("FAIL mix_valid[%0d]: got %b expected %b", i, bus.valid_out, exp_valid);
         end
         if (bus.data_out !== exp_data) begin
            mismatched++; $display("FAIL mix_data[%0d]: got %h expected %h", i, bus.data_out, exp_data);
         end
         if (bus.inj_flag !== 2'(exp_flag)) begin
            mismatched++; $display("FAIL mix_flag[%0d]: got %0d expected %0d", i, bus.inj_flag, exp_flag);
         end
         if (bus.inj_count !== 16'(m_count)) begin
            mismatched++; $display("FAIL mix_count[%0d]: got %0d expected %0d", i, bus.inj_count, m_count);
         end
      end
      clear_inputs();
      step();
   endtask

   task automatic test_reset_mid_arm();
      logic [71:0] d, cw;
      logic [1:0]  dec;
      int          p0, p1;
      do_reset();
      bus.inj_cont = 1'b1;
      bus.inj_mode = 3'd1;
      bus.inj_pos0 = 7'd3;
      step();
      send(rand72());
      bus.inj_cont = 1'b0;
      step();
      bus.inj_arm = 1'b1;
      step();
      bus.inj_arm = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      compared += 3;
      if (bus.data_out !== 72'h0) begin
         mismatched++; $display("FAIL async_data: got %h expected 0", bus.data_out);
      end
      if (bus.inj_flag !== 2'd0) begin
         mismatched++; $display("FAIL async_flag: got %0d expected 0", bus.inj_flag);
      end
      if (bus.inj_count !== 16'd0) begin
         mismatched++; $display("FAIL async_count: got %0d expected 0", bus.inj_count);
      end
      step();
      rst_n   = 1'b1;
      m_lfsr  = c_seed;
      m_count = 0;
      d = rand72();
      send(d);
      compared += 3;
      if (bus.data_out !== d) begin
         mismatched++; $display("FAIL post_rst_data: got %h expected %h", bus.data_out, d);
      end
      if (bus.inj_flag !== 2'd0) begin
         mismatched++; $display("FAIL post_rst_flag: got %0d expected 0", bus.inj_flag);
      end
      if (bus.inj_count !== 16'd0) begin
         mismatched++; $display("FAIL post_rst_count: got %0d expected 0", bus.inj_count);
      end
      cw = ecc_encode({$urandom(), $urandom()});
      bus.inj_pos0 = 7'($urandom_range(0, 71));
      bus.inj_arm  = 1'b1;
      step();
      bus.inj_arm = 1'b0;
      send(cw);
      dec = ecc_decode(bus.data_out);
      compared++;
      if (dec !== 2'b01) begin
         mismatched++; $display("FAIL dec_single: got {dbl,sgl}=%b expected 01", dec);
      end
      p0 = int'($urandom_range(0, 71));
      p1 = (p0 + 1 + int'($urandom_range(0, 70))) % 72;
      bus.inj_mode = 3'd2;
      bus.inj_pos0 = 7'(p0);
      bus.inj_pos1 = 7'(p1);
      bus.inj_cont = 1'b1;
      step();
      send(cw);
      dec = ecc_decode(bus.data_out);
      compared++;
      if (dec !== 2'b10) begin
         mismatched++; $display("FAIL dec_double: got {dbl,sgl}=%b expected 10", dec);
      end
      clear_inputs();
      step();
   endtask

   initial begin
      test_reset();
      test_mode0_cont();
      test_fixed_single_arm();
      test_fixed_double_cont();
      test_boundaries();
      test_random_double();
      test_random_mixed();
      test_reset_mid_arm();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
